// File: rtl/btn_pulse_gen_pkg.sv
// ----------------------------------------------------------------------------
// btn_pulse_gen_pkg
//   Shared definitions for the push-button pulse generator:
//   - FSM state encoding (IDLE=0, HOLD=1, DELAY=2, REPEAT=3)
//   - constant helper functions for sizing the debounce counter and timer
// ----------------------------------------------------------------------------
package btn_pulse_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_DELAY  = 2'd2,
        ST_REPEAT = 2'd3
    } btn_state_e;

    // Bits needed to address v distinct values (0 for v <= 1).
    function automatic int unsigned clog2_fn(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int unsigned max_fn(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_pulse_gen_debounce.sv
// ----------------------------------------------------------------------------
// btn_pulse_gen_debounce
//   Synchroniser chain plus debounce counter for a raw push-button.
//   Ports:
//     clk      in  clock
//     rst_n    in  asynchronous active-low reset
//     btn_raw  in  raw button, asynchronous to clk, raw polarity
//     level    out debounced, normalised level (1 = pressed)
//     rise     out one-cycle strobe, registered with the 0->1 change of level
//     fall     out one-cycle strobe, registered with the 1->0 change of level
// ----------------------------------------------------------------------------
module btn_pulse_gen_debounce
    import btn_pulse_gen_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned ACTIVE_LOW      = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam logic        RELEASED = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam int unsigned CNT_W    = (clog2_fn(DEBOUNCE_CYCLES + 1) < 1) ? 1
                                       : clog2_fn(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_chain_q, sync_chain_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   sync_level;

    // The chain carries raw polarity so reset can load the released level;
    // normalisation happens at the chain output.
    assign sync_level = sync_chain_q[SYNC_STAGES-1] ^ RELEASED;

    always_comb begin
        sync_chain_d = {sync_chain_q[SYNC_STAGES-2:0], btn_raw};
        cnt_d        = cnt_q;
        level_d      = level_q;
        rise_d       = 1'b0;
        fall_d       = 1'b0;
        if (sync_level == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            // Stable for DEBOUNCE_CYCLES cycles: accept the new level.
            cnt_d   = '0;
            level_d = ~level_q;
            rise_d  = ~level_q;
            fall_d  = level_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_chain_q <= {SYNC_STAGES{RELEASED}};
            cnt_q        <= '0;
            level_q      <= 1'b0;
            rise_q       <= 1'b0;
            fall_q       <= 1'b0;
        end else begin
            sync_chain_q <= sync_chain_d;
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/btn_pulse_gen.sv
// ----------------------------------------------------------------------------
// btn_pulse_gen
//   Push-button front end for a counter enable: synchronise, debounce, emit a
//   one-cycle pulse per accepted press, and optionally auto-repeat while held.
//   Ports:
//     clk        in  clock
//     rst_n      in  asynchronous active-low reset
//     btn_raw    in  raw button, asynchronous to clk
//     repeat_en  in  arms auto-repeat; sampled at press acceptance and while held
//     pulse      out one-cycle strobe per accepted press and per repeat
//     level      out debounced, normalised button level
//     repeating  out high while in the REPEAT state
// ----------------------------------------------------------------------------
module btn_pulse_gen
    import btn_pulse_gen_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned REPEAT_DELAY    = 1000,
    parameter int unsigned REPEAT_PERIOD   = 200,
    parameter int unsigned ACTIVE_LOW      = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    input  logic repeat_en,
    output logic pulse,
    output logic level,
    output logic repeating
);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("btn_pulse_gen: SYNC_STAGES must be >= 2 and cycle parameters >= 1");
    end

    localparam int unsigned TMR_MAX = max_fn(REPEAT_DELAY, REPEAT_PERIOD);
    localparam int unsigned TMR_W   = (clog2_fn(TMR_MAX + 1) < 1) ? 1
                                      : clog2_fn(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] DELAY_LAST  = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(REPEAT_PERIOD - 1);

    logic deb_level;
    logic deb_rise;
    logic deb_fall;

    btn_pulse_gen_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_debounce (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_raw),
        .level   (deb_level),
        .rise    (deb_rise),
        .fall    (deb_fall)
    );

    btn_state_e       state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             pulse_q, pulse_d;
    logic             level_q, level_d;
    logic             repeating_q, repeating_d;

    // The debounce strobes are registered, so the output stage adds one cycle;
    // level and the press pulse therefore appear on the same edge.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        pulse_d     = 1'b0;
        level_d     = deb_level;

        if (deb_fall) begin
            // Release has priority over any pending timer expiry.
            state_d = ST_IDLE;
            timer_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (deb_rise) begin
                        pulse_d = 1'b1;
                        state_d = repeat_en ? ST_DELAY : ST_HOLD;
                        timer_d = '0;
                    end
                end
                ST_HOLD: begin
                    // Only a fresh press can arm repeat.
                end
                ST_DELAY: begin
                    if (!repeat_en) begin
                        state_d = ST_HOLD;
                        timer_d = '0;
                    end else if (timer_q == DELAY_LAST) begin
                        pulse_d = 1'b1;
                        state_d = ST_REPEAT;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                ST_REPEAT: begin
                    if (!repeat_en) begin
                        state_d = ST_HOLD;
                        timer_d = '0;
                    end else if (timer_q == PERIOD_LAST) begin
                        pulse_d = 1'b1;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end
            endcase
        end

        repeating_d = (state_d == ST_REPEAT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            pulse_q     <= 1'b0;
            level_q     <= 1'b0;
            repeating_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            pulse_q     <= pulse_d;
            level_q     <= level_d;
            repeating_q <= repeating_d;
        end
    end

    assign pulse     = pulse_q;
    assign level     = level_q;
    assign repeating = repeating_q;

endmodule

// File: tb/tb_btn_pulse_gen.sv
// ----------------------------------------------------------------------------
// tb_btn_pulse_gen
//   Directed bench for btn_pulse_gen with SYNC_STAGES=2, DEBOUNCE_CYCLES=4,
//   REPEAT_DELAY=10, REPEAT_PERIOD=3. An active-low instance runs alongside,
//   driven with the inverted button, and must track the active-high one.
//   Edge numbering: the edge right after btn_raw changes is edge 0.
// ----------------------------------------------------------------------------
module tb_btn_pulse_gen;

    logic clk;
    logic rst_n;
    logic btn_raw;
    logic btn_raw_al;
    logic repeat_en;
    logic pulse, level, repeating;
    logic pulse_al, level_al, repeating_al;
    logic [7:0] cnt, cnt_al;

    int n_tests = 0;
    int n_fail  = 0;

    assign btn_raw_al = ~btn_raw;

    btn_pulse_gen #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3),
        .ACTIVE_LOW      (0)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (btn_raw),
        .repeat_en (repeat_en),
        .pulse     (pulse),
        .level     (level),
        .repeating (repeating)
    );

    btn_pulse_gen #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3),
        .ACTIVE_LOW      (1)
    ) u_dut_al (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (btn_raw_al),
        .repeat_en (repeat_en),
        .pulse     (pulse_al),
        .level     (level_al),
        .repeating (repeating_al)
    );

    // Downstream counters fed by pulse, as in the real system.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            cnt_al <= '0;
        end else begin
            if (pulse)    cnt    <= cnt + 8'd1;
            if (pulse_al) cnt_al <= cnt_al + 8'd1;
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulse offsets with DELAY=10, PERIOD=3 while held for 30 cycles.
    function automatic logic rep_pulse(input int off);
        return (off == 0) || (off == 10) || (off > 10 && off <= 28 && ((off - 10) % 3) == 0);
    endfunction

    logic [7:0] base;

    initial begin
        rst_n     = 1'b0;
        btn_raw   = 1'b0;
        repeat_en = 1'b0;
        ticks(2);

        // Reset state
        chk1("rst_pulse", pulse, 1'b0);
        chk1("rst_level", level, 1'b0);
        chk1("rst_repeating", repeating, 1'b0);
        chk1("rst_level_al", level_al, 1'b0);
        chk1("rst_pulse_al", pulse_al, 1'b0);
        rst_n = 1'b1;
        ticks(3);

        // 1: three-cycle blip is rejected
        btn_raw = 1'b1;
        ticks(3);
        btn_raw = 1'b0;
        for (int e = 3; e < 14; e++) begin
            tick();
            chk1("s1_level", level, 1'b0);
            chk1("s1_pulse", pulse, 1'b0);
        end
        chk8("s1_count", cnt, 8'd0);

        // 2 and 6: single press, no repeat, both polarities
        base = cnt;
        btn_raw = 1'b1;
        for (int e = 0; e < 40; e++) begin
            tick();
            chk1("s2_level", level, e >= 6);
            chk1("s2_pulse", pulse, e == 6);
            chk1("s6_level_al", level_al, e >= 6);
            chk1("s6_pulse_al", pulse_al, e == 6);
            chk1("s2_repeating", repeating, 1'b0);
        end
        btn_raw = 1'b0;
        for (int e = 0; e < 10; e++) begin
            tick();
            chk1("s2_rel_level", level, e < 6);
            chk1("s2_rel_pulse", pulse, 1'b0);
            chk1("s6_rel_level_al", level_al, e < 6);
            chk1("s6_rel_pulse_al", pulse_al, 1'b0);
        end
        chk8("s2_count", cnt, base + 8'd1);
        chk8("s6_count_al", cnt_al, base + 8'd1);

        // 3: bouncing input, then steady press
        base = cnt;
        for (int i = 0; i < 12; i++) begin
            btn_raw = ((i / 2) % 2) == 0;
            tick();
            chk1("s3_bounce_level", level, 1'b0);
        end
        btn_raw = 1'b1;
        for (int e = 12; e < 25; e++) begin
            tick();
            chk1("s3_level", level, e >= 18);
            chk1("s3_pulse", pulse, e == 18);
        end
        chk8("s3_count", cnt, base + 8'd1);
        btn_raw = 1'b0;
        ticks(10);
        chk1("s3_released", level, 1'b0);

        // 4: auto-repeat, then repeat_en drops exactly on an expiry cycle
        base = cnt;
        repeat_en = 1'b1;
        btn_raw   = 1'b1;
        ticks(7);
        chk1("s4_first_pulse", pulse, 1'b1);
        chk1("s4_rep_off0", repeating, 1'b0);
        for (int off = 1; off <= 30; off++) begin
            tick();
            chk1("s4_pulse", pulse, rep_pulse(off));
            chk1("s4_repeating", repeating, off >= 10);
        end
        repeat_en = 1'b0;
        tick();
        chk1("s4_drop_pulse", pulse, 1'b0);
        chk1("s4_drop_repeating", repeating, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk1("s4_hold_pulse", pulse, 1'b0);
        end
        chk8("s4_count", cnt, base + 8'd8);
        btn_raw = 1'b0;
        ticks(10);

        // 5a: release lands on the expiry cycle at offset 16
        repeat_en = 1'b1;
        btn_raw   = 1'b1;
        ticks(7);
        chk1("s5_first_pulse", pulse, 1'b1);
        ticks(9);
        btn_raw = 1'b0;
        for (int off = 10; off <= 17; off++) begin
            tick();
            chk1("s5_pulse", pulse, (off == 10) || (off == 13));
            chk1("s5_level", level, off < 16);
            chk1("s5_repeating", repeating, (off >= 10) && (off < 16));
        end
        ticks(8);

        // 5b: asynchronous reset while repeating
        btn_raw = 1'b1;
        ticks(7);
        ticks(10);
        chk1("s5_pre_rst_pulse", pulse, 1'b1);
        chk1("s5_pre_rst_rep", repeating, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("s5_rst_pulse", pulse, 1'b0);
        chk1("s5_rst_level", level, 1'b0);
        chk1("s5_rst_repeating", repeating, 1'b0);
        chk1("s5_rst_level_al", level_al, 1'b0);
        ticks(2);
        repeat_en = 1'b0;
        rst_n = 1'b1;
        for (int e = 0; e < 10; e++) begin
            tick();
            chk1("s5_post_pulse", pulse, e == 6);
            chk1("s5_post_level", level, e >= 6);
            chk1("s5_post_repeating", repeating, 1'b0);
        end
        chk8("s5_post_count", cnt, 8'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
